// File: rtl/mem_bank_be.sv
`default_nettype none
// ============================================================================
// Module   : mem_bank_be
// Brief    : Single-port synchronous memory bank with valid/ready requests,
//            byte-enable writes, configurable read latency and a post-reset
//            hardware clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bank_be #(
    parameter int DW     = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH),
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            r_w,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wr_d,
    input  logic [DW/8-1:0] be,
    output logic            rd_valid,
    output logic [DW-1:0]   rd_d,
    output logic            err,
    output logic            init_done
);

    localparam int            c_NUM_BYTES = DW / 8;
    localparam logic [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   c_DEPTH_EXT = (AW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_cnt;
    logic [AW-1:0]   w_clr_cnt_nxt;

    logic [DW-1:0]   r_mem [DEPTH];

    logic            w_accept;
    logic            w_in_range;
    logic            w_wr_en;
    logic            w_rd_en;
    logic [DW-1:0]   w_rd_word;

    logic [RD_LAT-1:0] r_pipe_vld;
    logic [RD_LAT-1:0] r_pipe_err;
    logic [DW-1:0]     r_pipe_d [RD_LAT];

    assign req_ready  = (r_state == S_RUN);
    assign init_done  = (r_state == S_RUN);

    assign w_accept   = req_valid && (r_state == S_RUN);
    assign w_in_range = ({1'b0, addr} < c_DEPTH_EXT);
    assign w_wr_en    = w_accept && r_w && w_in_range;
    assign w_rd_en    = w_accept && !r_w;
    assign w_rd_word  = w_in_range ? r_mem[addr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_cnt == c_LAST_ADDR) begin
                    w_state_nxt   = S_RUN;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + AW'(1);
                end
            end
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // Storage itself is not reset; the clear sweep provides the zero state.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < c_NUM_BYTES; i++) begin
                if (be[i]) begin
                    r_mem[addr][8*i +: 8] <= wr_d[8*i +: 8];
                end
            end
        end
    end

    // Data stages load only behind a valid read so the last stage holds rd_d.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_vld <= '0;
            r_pipe_err <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_pipe_d[k] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_rd_en;
            r_pipe_err[0] <= w_accept && !w_in_range;
            if (w_rd_en) begin
                r_pipe_d[0] <= w_rd_word;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
                r_pipe_err[k] <= r_pipe_err[k-1];
                if (r_pipe_vld[k-1]) begin
                    r_pipe_d[k] <= r_pipe_d[k-1];
                end
            end
        end
    end

    assign rd_valid = r_pipe_vld[RD_LAT-1];
    assign err      = r_pipe_err[RD_LAT-1];
    assign rd_d     = r_pipe_d[RD_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_mem_bank_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bank_be
// Brief    : Scoreboard bench driving two mem_bank_be instances (12 words /
//            3-cycle latency and 16 words / 1-cycle latency) from one stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bank_be;

    typedef struct {
        logic        rv;
        logic        er;
        logic [31:0] d;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        r_w = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wr_d = '0;
    logic [3:0]  be = '0;

    logic        a_req_ready, a_rd_valid, a_err, a_init_done;
    logic [31:0] a_rd_d;
    logic        b_req_ready, b_rd_valid, b_err, b_init_done;
    logic [31:0] b_rd_d;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    bit          running = 1'b0;

    exp_t        q [2][$];
    logic [31:0] mem_m [2][16];
    logic [31:0] last_rd [2];

    localparam int c_DEPTH [2] = '{12, 16};
    localparam int c_LAT   [2] = '{3, 1};

    mem_bank_be #(.DW(32), .DEPTH(12), .RD_LAT(3)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
        .r_w(r_w), .addr(addr), .wr_d(wr_d), .be(be), .rd_valid(a_rd_valid),
        .rd_d(a_rd_d), .err(a_err), .init_done(a_init_done)
    );

    mem_bank_be #(.DW(32), .DEPTH(16), .RD_LAT(1)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
        .r_w(r_w), .addr(addr), .wr_d(wr_d), .be(be), .rd_valid(b_rd_valid),
        .rd_d(b_rd_d), .err(b_err), .init_done(b_init_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_port(input int p, input logic v, input logic e,
                              input logic [31:0] d, input logic done);
        exp_t x;
        while (q[p].size() > 0 && q[p][0].due < cyc) begin
            x = q[p].pop_front();
            chk($sformatf("missing_out_%0d", p), 32'(cyc), 32'(x.due));
        end
        if (v || e) begin
            if (q[p].size() == 0 || q[p][0].due != cyc) begin
                chk($sformatf("unexpected_out_%0d", p), {30'b0, v, e}, 32'h0);
            end else begin
                x = q[p].pop_front();
                chk($sformatf("rd_valid_%0d", p), {31'b0, v}, {31'b0, x.rv});
                chk($sformatf("err_%0d", p), {31'b0, e}, {31'b0, x.er});
                if (x.rv) begin
                    chk($sformatf("rd_d_%0d", p), d, x.d);
                    last_rd[p] = x.d;
                end
            end
        end
        if (!v) chk($sformatf("rd_d_hold_%0d", p), d, last_rd[p]);
        if (running) chk($sformatf("init_done_%0d", p), {31'b0, done}, 32'h1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_port(0, a_rd_valid, a_err, a_rd_d, a_init_done);
            check_port(1, b_rd_valid, b_err, b_rd_d, b_init_done);
        end
    end

    // Reference behaviour: a plain word array updated in request order.
    task automatic model(input int p, input logic rw, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        exp_t x;
        x.due = cyc + c_LAT[p];
        x.d   = '0;
        if (rw) begin
            if (int'(a) < c_DEPTH[p]) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) mem_m[p][a][8*i +: 8] = d[8*i +: 8];
            end else begin
                x.rv = 1'b0;
                x.er = 1'b1;
                q[p].push_back(x);
            end
        end else begin
            x.rv = 1'b1;
            x.er = (int'(a) >= c_DEPTH[p]);
            if (!x.er) x.d = mem_m[p][a];
            q[p].push_back(x);
        end
    endtask

    task automatic issue(input logic rw, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        @(negedge clk); #1;
        req_valid = 1'b1;
        r_w = rw; addr = a; wr_d = d; be = b;
        model(0, rw, a, d, b);
        model(1, rw, a, d, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            req_valid = 1'b0;
            r_w  = 1'($urandom);
            addr = 4'($urandom);
            wr_d = $urandom;
            be   = 4'($urandom);
        end
    endtask

    task automatic do_reset();
        int cnt_a, cnt_b;
        @(negedge clk); #1;
        rst = 1'b1;
        req_valid = 1'b0;
        running = 1'b0;
        for (int p = 0; p < 2; p++) begin
            q[p].delete();
            last_rd[p] = '0;
            for (int w = 0; w < 16; w++) mem_m[p][w] = '0;
        end
        mon_en = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_req_ready_a", {31'b0, a_req_ready}, 32'h0);
        chk("rst_rd_valid_a",  {31'b0, a_rd_valid},  32'h0);
        chk("rst_err_a",       {31'b0, a_err},       32'h0);
        chk("rst_init_done_a", {31'b0, a_init_done}, 32'h0);
        chk("rst_rd_d_a",      a_rd_d,               32'h0);
        chk("rst_req_ready_b", {31'b0, b_req_ready}, 32'h0);
        chk("rst_rd_valid_b",  {31'b0, b_rd_valid},  32'h0);
        chk("rst_err_b",       {31'b0, b_err},       32'h0);
        chk("rst_init_done_b", {31'b0, b_init_done}, 32'h0);
        chk("rst_rd_d_b",      b_rd_d,               32'h0);
        rst = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 40; k++) begin
            if (!a_req_ready) cnt_a++;
            if (!b_req_ready) cnt_b++;
            if (a_req_ready && b_req_ready) break;
            @(negedge clk);
        end
        chk("sweep_cycles_a", 32'(cnt_a), 32'd12);
        chk("sweep_cycles_b", 32'(cnt_b), 32'd16);
        chk("sweep_done_a", {31'b0, a_init_done}, 32'h1);
        chk("sweep_done_b", {31'b0, b_init_done}, 32'h1);
        running = 1'b1;
    endtask

    task automatic read_all();
        for (int k = 0; k < 16; k++) issue(1'b0, 4'(k), '0, '0);
        idle(1);
    endtask

    initial begin
        do_reset();

        read_all();
        idle(4);

        // byte-enable merge
        issue(1'b1, 4'd5, 32'hAABBCCDD, 4'hF);
        issue(1'b1, 4'd5, 32'h11223344, 4'b0101);
        issue(1'b0, 4'd5, '0, '0);
        idle(4);

        // streaming writes then back-to-back reads
        for (int k = 0; k < 16; k++) issue(1'b1, 4'(k), 32'(k) * 32'h01010101, 4'hF);
        read_all();
        idle(4);

        // read-after-write on consecutive accepts
        issue(1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
        issue(1'b0, 4'd3, '0, '0);
        idle(4);

        // out-of-range on the 12-word bank, zero-enable write
        issue(1'b1, 4'd13, 32'hFFFFFFFF, 4'hF);
        issue(1'b0, 4'd13, '0, '0);
        issue(1'b1, 4'd7, 32'h55555555, 4'h0);
        read_all();
        idle(4);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) != 0)
                issue(1'($urandom), 4'($urandom_range(0, 15)), $urandom, 4'($urandom));
            else
                idle(1);
        end
        idle(5);

        // reset with reads in flight, then verify re-cleared contents
        issue(1'b0, 4'd1, '0, '0);
        issue(1'b0, 4'd2, '0, '0);
        do_reset();
        read_all();
        idle(6);

        chk("queue_empty_a", 32'(q[0].size()), 32'd0);
        chk("queue_empty_b", 32'(q[1].size()), 32'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
